// File: rtl/perceptron_trainer_if.sv
// Sample stream between the training-set source and the perceptron trainer.
// The source drives valid/data/last; the trainer answers with ready.
interface perceptron_trainer_if #(
    parameter int N_IN = 2,
    parameter int XW   = 7
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N_IN*XW-1:0]   in_x;
    logic                 in_t;
    logic                 in_last;

    modport master (output in_valid, in_x, in_t, in_last, input in_ready);
    modport slave  (input in_valid, in_x, in_t, in_last, output in_ready);
endinterface

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: buffers up to DEPTH samples, then runs epochs over them
// until one epoch makes no weight updates or MAX_EPOCHS is reached.
module perceptron_trainer #(
    parameter int N_IN       = 2,
    parameter int XW         = 7,
    parameter int WW         = 14,
    parameter int ALPHA      = 3,
    parameter int DEPTH      = 16,
    parameter int MAX_EPOCHS = 15,
    localparam int EW        = $clog2(MAX_EPOCHS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    perceptron_trainer_if.slave   in_if,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic [EW-1:0]         epochs,
    output logic [N_IN*WW-1:0]    w,
    output logic [WW-1:0]         b
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = N_IN * XW + 1;
    localparam int YW = XW + WW + $clog2(N_IN + 1) + 1;
    localparam int SW = ((WW > XW + 4) ? WW : XW + 4) + 2;
    localparam logic signed [3:0]    ALPHA_S = 4'(ALPHA);
    localparam logic signed [SW-1:0] SAT_HI  = SW'((2 ** (WW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO  = SW'(-(2 ** (WW - 1)));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_UPDATE,
        S_EPOCH,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [DW-1:0]          mem_q [DEPTH];
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          count_q, count_d;
    logic [EW-1:0]          epochs_q, epochs_d;
    logic                   err_q, err_d;
    logic                   conv_q, conv_d;
    logic signed [WW-1:0]   w_q [N_IN];
    logic signed [WW-1:0]   w_d [N_IN];
    logic signed [WW-1:0]   b_q, b_d;

    logic [DW-1:0]          cur;
    logic                   cur_t;
    logic signed [XW-1:0]   x_s [N_IN];
    logic signed [YW-1:0]   yin, prod;
    logic signed [SW-1:0]   step, acc;
    logic signed [WW-1:0]   w_upd [N_IN];
    logic signed [WW-1:0]   b_upd;
    logic                   match, last_idx, epoch_lim, hs, start_ok, wr_en;
    logic [DW-1:0]          wr_data;

    function automatic logic signed [WW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_HI) return WW'(SAT_HI);
        if (v < SAT_LO) return WW'(SAT_LO);
        return WW'(v);
    endfunction

    // Current sample: target in bit 0, features packed above it.
    always_comb begin
        cur   = mem_q[idx_q];
        cur_t = cur[0];
        for (int unsigned i = 0; i < N_IN; i++) begin
            x_s[i] = cur[1 + i*XW +: XW];
        end
    end

    always_comb begin
        prod = '0;
        yin  = YW'(b_q);
        for (int unsigned i = 0; i < N_IN; i++) begin
            prod = YW'(x_s[i]) * YW'(w_q[i]);
            yin  = yin + prod;
        end
        match = ((~yin[YW-1]) == cur_t);
    end

    always_comb begin
        step = '0;
        acc  = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            step     = SW'(ALPHA_S) * SW'(x_s[i]);
            acc      = cur_t ? (SW'(w_q[i]) + step) : (SW'(w_q[i]) - step);
            w_upd[i] = sat(acc);
        end
        acc   = cur_t ? (SW'(b_q) + SW'(ALPHA_S)) : (SW'(b_q) - SW'(ALPHA_S));
        b_upd = sat(acc);
    end

    assign last_idx  = (CW'(idx_q) == (count_q - CW'(1)));
    assign epoch_lim = (epochs_q == EW'(MAX_EPOCHS - 1));
    assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign hs        = in_if.in_valid && in_if.in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok) state_d = S_LOAD;
            S_LOAD: begin
                if (hs && (in_if.in_last || (count_q == CW'(DEPTH - 1)))) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (!match)        state_d = S_UPDATE;
                else if (last_idx) state_d = S_EPOCH;
            end
            S_UPDATE: state_d = last_idx ? S_EPOCH : S_EVAL;
            S_EPOCH:  state_d = (!err_q || epoch_lim) ? S_DONE : S_EVAL;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_if.in_ready = (state_q == S_LOAD);
        busy           = (state_q == S_LOAD) || (state_q == S_EVAL) ||
                         (state_q == S_UPDATE) || (state_q == S_EPOCH);
        done           = (state_q == S_DONE);
    end

    always_comb begin
        idx_d    = idx_q;
        count_d  = count_q;
        epochs_d = epochs_q;
        err_d    = err_q;
        conv_d   = conv_q;
        b_d      = b_q;
        for (int unsigned i = 0; i < N_IN; i++) w_d[i] = w_q[i];
        wr_en    = 1'b0;
        wr_data  = {in_if.in_x, in_if.in_t};
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    idx_d    = '0;
                    count_d  = '0;
                    epochs_d = '0;
                    err_d    = 1'b0;
                    conv_d   = 1'b0;
                    b_d      = '0;
                    for (int unsigned i = 0; i < N_IN; i++) w_d[i] = '0;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            S_EVAL: begin
                if (match && !last_idx) idx_d = idx_q + IW'(1);
            end
            S_UPDATE: begin
                for (int unsigned i = 0; i < N_IN; i++) w_d[i] = w_upd[i];
                b_d   = b_upd;
                err_d = 1'b1;
                if (!last_idx) idx_d = idx_q + IW'(1);
            end
            S_EPOCH: begin
                epochs_d = epochs_q + EW'(1);
                if (!err_q) begin
                    conv_d = 1'b1;
                end else if (epoch_lim) begin
                    conv_d = 1'b0;
                end else begin
                    err_d = 1'b0;
                    idx_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q    <= '0;
            count_q  <= '0;
            epochs_q <= '0;
            err_q    <= 1'b0;
            conv_q   <= 1'b0;
            b_q      <= '0;
            for (int unsigned i = 0; i < N_IN; i++) w_q[i] <= '0;
        end else begin
            idx_q    <= idx_d;
            count_q  <= count_d;
            epochs_q <= epochs_d;
            err_q    <= err_d;
            conv_q   <= conv_d;
            b_q      <= b_d;
            for (int unsigned i = 0; i < N_IN; i++) w_q[i] <= w_d[i];
        end
    end

    // Sample storage is not reset; its content only matters after a LOAD.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[count_q[IW-1:0]] <= wr_data;
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_w_out
        assign w[g*WW +: WW] = w_q[g];
    end

    assign b         = b_q;
    assign epochs    = epochs_q;
    assign converged = conv_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: a WW=14 and a WW=8 instance, checked against
// an integer-arithmetic model of perceptron training.
module tb_perceptron_trainer;

    localparam int DEPTH = 16;
    localparam int MAXE  = 15;
    localparam int ALPHA = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic        busy_a, done_a, conv_a;
    logic [3:0]  ep_a;
    logic [27:0] w_a;
    logic [13:0] b_a;
    logic        busy_b, done_b, conv_b;
    logic [3:0]  ep_b;
    logic [15:0] w_b;
    logic [7:0]  b_b;

    perceptron_trainer_if #(.N_IN(2), .XW(7)) ifa ();
    perceptron_trainer_if #(.N_IN(2), .XW(7)) ifb ();

    perceptron_trainer #(
        .N_IN(2), .XW(7), .WW(14), .ALPHA(3), .DEPTH(16), .MAX_EPOCHS(15)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_if(ifa),
        .busy(busy_a), .done(done_a), .converged(conv_a), .epochs(ep_a),
        .w(w_a), .b(b_a)
    );

    perceptron_trainer #(
        .N_IN(2), .XW(7), .WW(8), .ALPHA(3), .DEPTH(16), .MAX_EPOCHS(15)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_if(ifb),
        .busy(busy_b), .done(done_b), .converged(conv_b), .epochs(ep_b),
        .w(w_b), .b(b_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int sx0[$];
    int sx1[$];
    int st[$];

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int ww);
        int lim;
        lim = 1 << (ww - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Plain perceptron rule over the first n samples of the queues.
    task automatic model(input int n, input int ww, output int w0, output int w1,
                         output int bb, output int ep, output int cv);
        bit err;
        int y, tt;
        w0 = 0; w1 = 0; bb = 0; ep = 0;
        do begin
            err = 0;
            for (int s = 0; s < n; s++) begin
                y = bb + sx0[s] * w0 + sx1[s] * w1;
                if ((y >= 0) != (st[s] == 1)) begin
                    tt  = st[s] ? 1 : -1;
                    w0  = sat(w0 + ALPHA * tt * sx0[s], ww);
                    w1  = sat(w1 + ALPHA * tt * sx1[s], ww);
                    bb  = sat(bb + ALPHA * tt, ww);
                    err = 1;
                end
            end
            ep++;
        end while (err && ep < MAXE);
        cv = err ? 0 : 1;
    endtask

    function automatic int rdy(input int sel);
        return sel ? int'(ifb.in_ready) : int'(ifa.in_ready);
    endfunction

    function automatic int get(input int sel, input int k);
        case (k)
            0: return sel ? int'($signed(w_b[7:0]))  : int'($signed(w_a[13:0]));
            1: return sel ? int'($signed(w_b[15:8])) : int'($signed(w_a[27:14]));
            2: return sel ? int'($signed(b_b))       : int'($signed(b_a));
            3: return sel ? int'(ep_b)   : int'(ep_a);
            4: return sel ? int'(conv_b) : int'(conv_a);
            5: return sel ? int'(done_b) : int'(done_a);
            default: return sel ? int'(busy_b) : int'(busy_a);
        endcase
    endfunction

    task automatic drive(input int sel, input bit v, input int x0, input int x1,
                         input bit t, input bit last);
        logic [13:0] xv;
        xv = {7'(x1), 7'(x0)};
        if (sel == 0) begin
            ifa.in_valid = v; ifa.in_x = xv; ifa.in_t = t; ifa.in_last = last;
        end else begin
            ifb.in_valid = v; ifb.in_x = xv; ifb.in_t = t; ifb.in_last = last;
        end
    endtask

    task automatic set_start(input int sel, input bit v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    task automatic gen(input int n, input int lo, input int hi);
        sx0.delete(); sx1.delete(); st.delete();
        for (int i = 0; i < n; i++) begin
            sx0.push_back(int'($urandom_range(hi - lo)) + lo);
            sx1.push_back(int'($urandom_range(hi - lo)) + lo);
            st.push_back(int'($urandom_range(1)));
        end
    endtask

    task automatic put(input int x0, input int x1, input int t);
        sx0.push_back(x0); sx1.push_back(x1); st.push_back(t);
    endtask

    task automatic load_set(input int sel, input int n, input bit use_last, output int acc);
        acc = 0;
        @(negedge clk); set_start(sel, 1'b1);
        @(negedge clk); set_start(sel, 1'b0);
        for (int i = 0; i < n; i++) begin
            drive(sel, 1'b1, sx0[i], sx1[i], st[i][0], use_last && (i == n - 1));
            if (rdy(sel) == 0) break;
            acc++;
            @(negedge clk);
        end
        drive(sel, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic run_set(input int sel, input int n, input bit use_last,
                           input bit poke, input string tag);
        int acc, m, cyc, mw0, mw1, mb, mep, mcv;
        load_set(sel, n, use_last, acc);
        m = (n > DEPTH) ? DEPTH : n;
        check({tag, "_accepted"}, acc, m);
        check({tag, "_ready_low"}, rdy(sel), 0);
        if (poke) begin
            // Restart and junk samples while evaluating must change nothing.
            set_start(sel, 1'b1);
            drive(sel, 1'b1, 60, -60, 1'b1, 1'b1);
            repeat (3) @(negedge clk);
            set_start(sel, 1'b0);
            drive(sel, 1'b0, 0, 0, 1'b0, 1'b0);
        end
        cyc = 0;
        while (get(sel, 5) == 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, get(sel, 5), 1);
        check({tag, "_busy"}, get(sel, 6), 0);
        model(m, sel ? 8 : 14, mw0, mw1, mb, mep, mcv);
        check({tag, "_w0"}, get(sel, 0), mw0);
        check({tag, "_w1"}, get(sel, 1), mw1);
        check({tag, "_b"}, get(sel, 2), mb);
        check({tag, "_epochs"}, get(sel, 3), mep);
        check({tag, "_converged"}, get(sel, 4), mcv);
    endtask

    task automatic and_set();
        sx0.delete(); sx1.delete(); st.delete();
        put(1, 1, 1); put(1, -1, 0); put(-1, 1, 0); put(-1, -1, 0);
    endtask

    task automatic check_and(input string tag);
        check({tag, "_c_w0"}, get(0, 0), 3);
        check({tag, "_c_w1"}, get(0, 1), 3);
        check({tag, "_c_b"}, get(0, 2), -3);
        check({tag, "_c_epochs"}, get(0, 3), 3);
        check({tag, "_c_conv"}, get(0, 4), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_w0"}, get(0, 0), 0);
        check({tag, "_w1"}, get(0, 1), 0);
        check({tag, "_b"}, get(0, 2), 0);
        check({tag, "_epochs"}, get(0, 3), 0);
        check({tag, "_conv"}, get(0, 4), 0);
        check({tag, "_done"}, get(0, 5), 0);
        check({tag, "_busy"}, get(0, 6), 0);
        check({tag, "_ready"}, rdy(0), 0);
    endtask

    initial begin
        int acc, cyc, n;
        drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
        drive(1, 1'b0, 0, 0, 1'b0, 1'b0);
        #7;
        check_zero("reset");
        @(negedge clk); rst = 1'b1;

        and_set();
        run_set(0, 4, 1'b1, 1'b1, "and");
        check_and("and");

        sx0.delete(); sx1.delete(); st.delete();
        put(1, 1, 0); put(1, -1, 1); put(-1, 1, 1); put(-1, -1, 0);
        run_set(0, 4, 1'b1, 1'b0, "xor");
        check("xor_c_epochs", get(0, 3), 15);
        check("xor_c_conv", get(0, 4), 0);

        // Reset asserted while the second epoch's EPOCH cycle is pending.
        and_set();
        load_set(0, 4, 1'b1, acc);
        cyc = 0;
        while (get(0, 3) != 1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_epoch1", get(0, 3), 1);
        repeat (5) @(negedge clk);
        check("mid_busy", get(0, 6), 1);
        rst = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk); rst = 1'b1;
        run_set(0, 4, 1'b1, 1'b0, "and2");
        check_and("and2");

        gen(20, -8, 8);
        run_set(0, 20, 1'b0, 1'b0, "ovf");

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(16, 1));
            gen(n, -8, 8);
            run_set(0, n, 1'b1, n >= 4, "rnd");
        end

        sx0.delete(); sx1.delete(); st.delete();
        put(-63, -63, 0);
        run_set(1, 1, 1'b1, 1'b0, "satpos");
        check("satpos_c_w0", get(1, 0), 127);
        check("satpos_c_w1", get(1, 1), 127);
        check("satpos_c_b", get(1, 2), -3);
        check("satpos_c_epochs", get(1, 3), 2);

        sx0.delete(); sx1.delete(); st.delete();
        put(63, 63, 0);
        run_set(1, 1, 1'b1, 1'b0, "satneg");
        check("satneg_c_w0", get(1, 0), -128);
        check("satneg_c_w1", get(1, 1), -128);

        sx0.delete(); sx1.delete(); st.delete();
        put(63, 63, 1);
        run_set(1, 1, 1'b1, 1'b0, "w8single");

        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(8, 2));
            gen(n, -64, 63);
            run_set(1, n, 1'b1, 1'b0, "rnd8");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
